// File: rtl/rs232_pkg.sv
// Shared RS-232 types and constants for the transmitter and receiver.
// RS232_TX_PARITY_EN adds the even-parity state and the 11-bit frame length.
package rs232_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1302;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS_8N1       = 10;
  localparam int unsigned FRAME_BITS_8E1       = 11;

`ifdef RS232_TX_PARITY_EN
  localparam int unsigned TX_FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int unsigned TX_FRAME_BITS = FRAME_BITS_8N1;
`endif

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef RS232_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4,
    TX_DONE   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/rs232_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, bit_tick on the last count.
// Latency: tick combinational from the count; no backpressure.
module rs232_baud_gen
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign bit_tick = (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = bit_tick ? 16'd0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rs232_tx_single_byte.sv
// Single-byte 8N1 RS-232 transmitter; tx falls one cycle after acceptance, ready only in IDLE/DONE.
// Define RS232_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module rs232_tx_single_byte
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       accept;
  logic       bit_tick;
  logic       baud_en;
`ifdef RS232_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign tx_ready = (state_q == TX_IDLE) || (state_q == TX_DONE);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    baud_en = 1'b0;
    case (state_q)
      TX_START, TX_DATA, TX_STOP: baud_en = 1'b1;
`ifdef RS232_TX_PARITY_EN
      TX_PARITY:                  baud_en = 1'b1;
`endif
      default:                    baud_en = 1'b0;
    endcase
  end

  assign tx_busy = baud_en;
  assign tx_done = done_q;
  assign tx      = tx_q;

  rs232_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (baud_en),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef RS232_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      TX_IDLE, TX_DONE: begin
        state_d = TX_IDLE;
        if (accept) begin
          state_d   = TX_START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
`ifdef RS232_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      TX_START: if (bit_tick) state_d = TX_DATA;
      TX_DATA: begin
        if (bit_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef RS232_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef RS232_TX_PARITY_EN
      TX_PARITY: if (bit_tick) state_d = TX_STOP;
`endif
      TX_STOP: if (bit_tick) state_d = TX_DONE;
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level follows the current state, so tx lags the state register by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_q[0];
`ifdef RS232_TX_PARITY_EN
      TX_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
    done_d = (state_q == TX_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef RS232_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_tx_single_byte.sv
// Directed + randomized bench for rs232_tx_single_byte at 4 clocks per bit.
// Honours RS232_TX_PARITY_EN for the 11-bit frame.
module tb_rs232_tx_single_byte;

  localparam int C = 4;
`ifdef RS232_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, tx;

  int n_checks = 0;
  int n_pass   = 0;

  logic cap_line [0:255];
  logic cap_done [0:255];

  rs232_tx_single_byte #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference line level j cycles after the frame starts: start, 8 data LSB first, [parity], stop, idle.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    int idx;
    idx = j / C;
    if (j < 0)                    return 1'b1;
    if (idx == 0)                 return 1'b0;
    if (idx <= 8)                 return b[idx-1];
    if (FB == 11 && idx == 9)     return ^b;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] b, output logic ok);
    ok = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    for (int w = 0; w < 200; w++) begin
      if (tx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic capture(input int n, input int drop_at, input int pulse_at,
                         input logic [7:0] pulse_dat, input int scramble_at);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      cap_line[j] = tx;
      cap_done[j] = tx_done;
      if (j == drop_at) tx_valid = 1'b0;
      if (pulse_at >= 0 && j == pulse_at + 1) tx_valid = 1'b0;
      if (j == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = pulse_dat;
      end
      if (j == scramble_at) tx_data = ~tx_data;
    end
  endtask

  task automatic check_single(input string tag, input logic [7:0] b, input int n);
    int cnt;
    int idx;
    cnt = 0;
    idx = -1;
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s line[%0d]", tag, j), 32'(cap_line[j]), 32'(frame_bit(b, j)));
      if (cap_done[j] === 1'b1) begin
        cnt = cnt + 1;
        if (idx < 0) idx = j;
      end
    end
    check({tag, " done_count"}, cnt, 1);
    check({tag, " done_cycle"}, idx + 1, FB * C + 1);
  endtask

  initial begin
    logic       ok;
    logic [7:0] rb;
    int         cnt, g, j2;
    int         idx1, idx2;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'b1100);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle[%0d]", i), {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'b1100);
    end

    // 0x55 frame
    send(8'h55, ok);
    check("accept_55", 32'(ok), 1);
    capture(FB * C + 6, 0, -1, 8'h00, -1);
    check_single("f55", 8'h55, FB * C + 6);

    // 0xA3 with a 0xFF pulse mid-frame, which must be dropped
    send(8'hA3, ok);
    check("accept_a3", 32'(ok), 1);
    capture(FB * C + 12, 0, 12, 8'hFF, -1);
    check_single("fa3", 8'hA3, FB * C + 12);
    check("a3_end_ready_busy", {30'd0, tx_ready, tx_busy}, 32'b10);

    // Random bytes; tx_data is scrambled after acceptance
    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, ok);
      check($sformatf("accept_rand%0d", r), 32'(ok), 1);
      capture(FB * C + 6, 0, -1, 8'h00, 3);
      check_single($sformatf("rand%0d_%02h", r, rb), rb, FB * C + 6);
    end

    // Back-to-back with tx_valid held: 0x01 then 0x80
    send(8'h01, ok);
    check("accept_01", 32'(ok), 1);
    tx_data = 8'h80;
    capture(2 * FB * C + 8, FB * C, -1, 8'h00, -1);
    cnt  = 0;
    idx1 = -1;
    idx2 = -1;
    for (int j = 0; j < 2 * FB * C + 8; j++) begin
      j2 = j - (FB * C + 1);
      check($sformatf("b2b line[%0d]", j), 32'(cap_line[j]),
            32'((j < FB * C + 1) ? frame_bit(8'h01, j) : frame_bit(8'h80, j2)));
      if (cap_done[j] === 1'b1) begin
        cnt = cnt + 1;
        if (idx1 < 0) idx1 = j;
        else if (idx2 < 0) idx2 = j;
      end
    end
    check("b2b done_count", cnt, 2);
    check("b2b done1_cycle", idx1 + 1, FB * C + 1);
    check("b2b done2_cycle", idx2 + 1, 2 * FB * C + 2);
    g  = 0;
    j2 = (FB - 1) * C;
    while (j2 < 2 * FB * C + 8 && cap_line[j2] === 1'b1) begin
      g  = g + 1;
      j2 = j2 + 1;
    end
    check("b2b gap", g, C + 1);

    // Reset during data bit 3 of 0x0F
    send(8'h0F, ok);
    check("accept_0f", 32'(ok), 1);
    tx_valid = 1'b0;
    capture(4 * C + 2, -1, -1, 8'h00, -1);
    for (int j = 0; j < 4 * C + 2; j++)
      check($sformatf("f0f line[%0d]", j), 32'(cap_line[j]), 32'(frame_bit(8'h0F, j)));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_after_edge", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(tx_ready), 1);
    capture(FB * C + 10, -1, -1, 8'h00, -1);
    cnt = 0;
    for (int j = 0; j < FB * C + 10; j++) begin
      if (cap_line[j] !== 1'b1 || cap_done[j] !== 1'b0) cnt = cnt + 1;
    end
    check("midrst_quiet_cycles", cnt, 0);

`ifdef RS232_TX_PARITY_EN
    send(8'h07, ok);
    check("accept_07", 32'(ok), 1);
    capture(FB * C + 6, 0, -1, 8'h00, -1);
    check_single("f07", 8'h07, FB * C + 6);
    check("f07 parity", 32'(cap_line[9 * C + 1]), 1);

    send(8'h03, ok);
    check("accept_03", 32'(ok), 1);
    capture(FB * C + 6, 0, -1, 8'h00, -1);
    check_single("f03", 8'h03, FB * C + 6);
    check("f03 parity", 32'(cap_line[9 * C + 1]), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs232_tx_single_byte.md
# rs232_tx_single_byte

Single-byte RS-232 transmitter: accepts one 8-bit word over a valid/ready handshake and serialises it onto `tx` as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a fixed bit period in clock cycles. It is the transmit-side counterpart of the single-byte receiver in the RS-232 package. It sits between user logic (or a loopback of received bytes) and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 1302: clock cycles per bit (50 MHz / 38400 baud); legal range 2..65535.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `tx_valid`  in  1  byte offered on `tx_data`.
- `tx_data`  in  8  byte to transmit; sampled only on acceptance.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx_busy`  out  1  frame in progress (start bit through stop bit).
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.
- `tx`  out  1  serial line, idle high, registered.

## Operation
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT (macro only), STOP_BIT, DONE.
- IDLE: `tx`=1, `tx_ready`=1. On `tx_valid && tx_ready`, latch `tx_data` into the shift register, clear the bit counter and the baud counter, and go to START_BIT.
- START_BIT: `tx`=0 for CLKS_PER_BIT cycles, then DATA_BITS.
- DATA_BITS: `tx` = shift_reg[0]. Every CLKS_PER_BIT cycles, shift right and increment the 3-bit bit counter. After bit 7 completes, go to PARITY_BIT if the macro is defined, otherwise STOP_BIT.
- STOP_BIT: `tx`=1 for CLKS_PER_BIT cycles, then DONE.
- DONE: one cycle. `tx_done`=1, `tx`=1, `tx_ready`=1. Acceptance in DONE goes straight to START_BIT; otherwise go to IDLE.
- `tx_ready` is combinational: high in IDLE or DONE. `tx_busy` is high in START_BIT through STOP_BIT.
- Baud counter is 16 bits, counts 0..CLKS_PER_BIT-1, and wraps to 0 at each bit boundary. The bit boundary fires when count == CLKS_PER_BIT-1.
- `tx_valid` while `tx_ready`=0 is ignored; the byte is not queued.
- Changes to `tx_data` after acceptance have no effect on the frame.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, counters=0, shift register=0. `tx_ready`=1 once state is IDLE.
- Reset mid-frame aborts the frame. `tx` is 1 from the next edge on, and no `tx_done` is issued.
- Acceptance at edge k: `tx` falls at edge k+1 and stays low for exactly CLKS_PER_BIT cycles.
- Each subsequent bit lasts exactly CLKS_PER_BIT cycles.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity), measured from edge k+1.
- `tx_done` is high for the single cycle after the last stop-bit cycle.
- Back-to-back transfer: minimum stop-to-next-start gap is CLKS_PER_BIT+1 high cycles (stop bit plus the DONE cycle).

## Configuration
- `RS232_TX_PARITY_EN` defined: an even-parity bit (`^data`) is sent for CLKS_PER_BIT cycles between bit 7 and the stop bit, making the frame 11 bits.
- Macro undefined: the PARITY_BIT state and its logic are absent, and the frame is plain 8N1.

## Structure
- Shared package `rs232_pkg`:
  - `tx_state_t` enum.
  - `DEFAULT_CLKS_PER_BIT = 1302`.
  - Frame-length constants.
- Sub-module `rs232_baud_gen`: the baud counter with `clear` and `enable` inputs and a `bit_tick` output (count == CLKS_PER_BIT-1). It is reusable by the receiver.

## Test plan
Benches use CLKS_PER_BIT=4 unless stated.
- Reset, then idle 20 cycles → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 throughout.
- Send 0x55 → line is 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit. `tx_done` pulses once, 41 cycles after acceptance.
- Send 0xA3, then pulse `tx_valid` with 0xFF during the frame → only the 0xA3 frame (0,1,1,0,0,0,1,0,1,1) is sent; 0xFF is dropped.
- Hold `tx_valid` high with 0x01 then 0x80 → both frames are sent; the gap between the first stop bit and the second start bit is exactly 5 high cycles.
- Assert `rst`=0 during bit 3 of 0x0F → `tx`=1 from the next edge, no `tx_done`, and `tx_ready`=1 after release.
- With `RS232_TX_PARITY_EN` defined, send 0x07 → parity bit 1 before the stop bit. Send 0x03 → parity bit 0. Frames are 44 cycles each.
